spi_device_arbiter: RTL and testbench
=====================================

# spi_device_arbiter

Shares the single SPI peripheral (`device`) between two SPI masters on the demo board: master 0 is the tiny processor's SPI pins (`uio_out[3]`, `uio_out[5]`, `uio_out[6]`), and master 1 is the FPGA-side driver/debug port. The block grants the device to one master per transaction, from chip-select low to chip-select high, using round-robin priority on ties. After each release it holds the device deselected for a turnaround gap. Master transactions that cannot be serviced are counted and masked, never spliced into another master's frame.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: clock cycles the device CS stays high after a release, before a new grant is allowed (range 1..15).
- `CNT_W`, default 8: width of each saturating collision counter.

Ports:
- `clk` in 1: system clock. All SPI inputs are synchronous to it.
- `rst` in 1: reset, synchronous, active-high.
- `m0_cs`, `m0_sclk`, `m0_mosi` in 1 each: master 0 (processor) SPI outputs. CS is active-low.
- `m0_miso` out 1: master 0 return data.
- `m1_cs`, `m1_sclk`, `m1_mosi` in 1 each: master 1 (driver) SPI outputs. CS is active-low.
- `m1_miso` out 1: master 1 return data.
- `d_cs`, `d_sclk`, `d_mosi` out 1 each: to the device.
- `d_miso` in 1: from the device.
- `grant` out 2: one-hot current owner (bit k = master k); 00 when no owner.
- `busy` out 1: high in any state other than IDLE.
- `coll_cnt0`, `coll_cnt1` out CNT_W: collision counts per master, saturating at all-ones.
- `clr_stats` in 1: synchronous clear of both counters.

## Operation
- States: IDLE, OWN0, OWN1, GAP.
- Registers:
  - `cs_q[1:0]`: previous-cycle CS of each master.
  - `blocked[1:0]`: masks a master until its CS returns high.
  - `last`: last owner.
  - `gap_cnt`: turnaround counter.
- "Request k" means `mk_cs==0 && !blocked[k]`.
- IDLE transitions:
  - Exactly one request → go to OWNk.
  - Both request → grant the master that is not `last`. The loser sets `blocked` and increments its counter.
  - No request → stay in IDLE.
- OWNk:
  - Stay in OWNk while `mk_cs==0`.
  - On `mk_cs==1`: set `last<=k`, load `gap_cnt<=GAP_CYCLES-1`, go to GAP.
- GAP: decrement `gap_cnt`. When it reaches 0, go to IDLE.
- Collision: a CS falling edge (`cs_q[j]==1 && mj_cs==0`) on master j is a collision when either:
  - the state is OWNk (k≠j) or GAP, or
  - master j loses a tie in IDLE.
  
  On a collision: set `blocked[j]` and increment `coll_cnt_j` once (per falling edge, not per cycle).
- Blocked flags: `blocked[j]` clears in any cycle where `mj_cs==1`. A master whose CS is already low in IDLE with `blocked` clear is granted; no edge is required.
- Routing in OWNk (combinational pass-through):
  - `d_cs=mk_cs`, `d_sclk=mk_sclk`, `d_mosi=mk_mosi`.
  - `mk_miso=d_miso`; the other master's MISO is 0.
- Routing in IDLE and GAP: `d_cs=1`, `d_sclk=0`, `d_mosi=0`, both MISO outputs 0.
- Outputs:
  - `grant` is decoded from state.
  - `busy = (state != IDLE)`.
- Counters:
  - `clr_stats` has priority over a same-cycle increment; the counter reads 0 next cycle.
  - Counters saturate at all-ones and do not wrap.
- Reset values:
  - State IDLE; `grant=00`, `busy=0`.
  - `d_cs=1`, `d_sclk=0`, `d_mosi=0`, `m0_miso=m1_miso=0`.
  - Counters 0; `last=1` (master 0 wins the first tie).
  - `cs_q=11`, `blocked=11`, `gap_cnt=0`.
- Reset mid-transaction: the device is deselected on the next cycle. Both masters stay masked until each drives CS high, so a half-finished frame is never resumed.

## Timing
- Grant latency: CS low sampled at edge t in IDLE → state OWNk after edge t; `d_cs` goes low in cycle t+1. Masters must hold SCLK idle for at least 1 clock after CS falls.
- Release: owner CS high at edge t → `d_cs` high in the same cycle (pass-through). The state is GAP for GAP_CYCLES cycles, and the earliest new `d_cs` low comes GAP_CYCLES+1 cycles after the release edge.
- Data path: zero-cycle combinational pass-through in both directions. No SCLK resynchronisation.
- Counter update: visible one cycle after the colliding CS falling edge.

## Test plan
- Single master: after reset, m0 holds CS high for 1 cycle, then drops CS and clocks 8 bits of 0xA5 with `d_miso` driven by the device → `grant=01` from the next cycle; `d_mosi` mirrors 0xA5; `m0_miso` returns device data; `m1_miso=0`; counters stay 0.
- Simultaneous request: both CS fall on the same edge right after reset → `grant=01`, `coll_cnt1=1`. m0 releases and m1 is held low → m1 is not granted until it raises CS. On the next tie → `grant=10` (round-robin), `coll_cnt0=1`.
- Mid-frame intrusion: m1 drops CS while `grant=01` → `d_cs` keeps following m0 only; `coll_cnt1` increments by exactly 1 even if m1 stays low 50 cycles.
- Gap enforcement: with GAP_CYCLES=2, m0 releases and m1 CS falls in the following cycle (during GAP) → collision counted, no grant; `d_cs` is high for ≥3 cycles.
- Saturation/clear: with CNT_W=8, force 300 m1 collisions → `coll_cnt1=255`. Assert `clr_stats` in the same cycle as a collision → counter reads 0.
- Reset mid-transaction: assert `rst` while `grant=10` with m1 CS held low → next cycle `d_cs=1`, `grant=00`. m1 is only re-granted after CS high then low.

Source files
------------

// File: rtl/spi_device_arbiter.sv
// spi_device_arbiter
// Shares one SPI device between two SPI masters, one whole transaction at a time.
// A transaction runs from chip-select low to chip-select high. Simultaneous
// requests are settled round-robin. Every release is followed by a deselected
// turnaround gap. Any master that drops CS while it cannot be served is counted
// and masked until it raises CS again, so its frame is never spliced into
// another master's frame.
module spi_device_arbiter #(
    parameter int GAP_CYCLES = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             m0_cs,
    input  logic             m0_sclk,
    input  logic             m0_mosi,
    output logic             m0_miso,
    input  logic             m1_cs,
    input  logic             m1_sclk,
    input  logic             m1_mosi,
    output logic             m1_miso,
    output logic             d_cs,
    output logic             d_sclk,
    output logic             d_mosi,
    input  logic             d_miso,
    output logic [1:0]       grant,
    output logic             busy,
    output logic [CNT_W-1:0] coll_cnt0,
    output logic [CNT_W-1:0] coll_cnt1,
    input  logic             clr_stats
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

    state_t             state_q, state_d;
    logic [1:0]         cs_q, cs_d;
    logic [1:0]         blocked_q, blocked_d;
    logic               last_q, last_d;
    logic [3:0]         gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]   coll_cnt0_q, coll_cnt0_d;
    logic [CNT_W-1:0]   coll_cnt1_q, coll_cnt1_d;
    logic [1:0]         grant_q, grant_d;
    logic               busy_q, busy_d;

    logic [1:0]         cs_now;
    logic [1:0]         req;
    logic [1:0]         fall;
    logic [1:0]         coll;

    assign cs_now = {m1_cs, m0_cs};
    assign req    = ~cs_now & ~blocked_q;
    assign fall   = cs_q & ~cs_now;

    // Ownership decisions: who gets the device next and which CS edges are collisions.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        coll      = 2'b00;
        case (state_q)
            IDLE: begin
                if (req == 2'b11) begin
                    // The master that did not own last time wins; the other loses the tie.
                    if (last_q) begin
                        state_d = OWN0;
                        coll[1] = 1'b1;
                    end else begin
                        state_d = OWN1;
                        coll[0] = 1'b1;
                    end
                end else if (req[0]) begin
                    state_d = OWN0;
                end else if (req[1]) begin
                    state_d = OWN1;
                end
            end
            OWN0: begin
                coll[1] = fall[1];
                if (m0_cs) begin
                    last_d    = 1'b0;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP;
                end
            end
            OWN1: begin
                coll[0] = fall[0];
                if (m1_cs) begin
                    last_d    = 1'b1;
                    gap_cnt_d = GAP_LOAD;
                    state_d   = GAP;
                end
            end
            GAP: begin
                coll = fall;
                if (gap_cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Masking, CS history, saturating collision counters and decoded status outputs.
    always_comb begin
        cs_d      = cs_now;
        blocked_d = (blocked_q | coll) & ~cs_now;

        coll_cnt0_d = coll_cnt0_q;
        if (clr_stats) begin
            coll_cnt0_d = '0;
        end else if (coll[0] && !(&coll_cnt0_q)) begin
            coll_cnt0_d = coll_cnt0_q + CNT_W'(1);
        end

        coll_cnt1_d = coll_cnt1_q;
        if (clr_stats) begin
            coll_cnt1_d = '0;
        end else if (coll[1] && !(&coll_cnt1_q)) begin
            coll_cnt1_d = coll_cnt1_q + CNT_W'(1);
        end

        case (state_d)
            OWN0:    grant_d = 2'b01;
            OWN1:    grant_d = 2'b10;
            default: grant_d = 2'b00;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Single state register for the arbiter, including its registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cs_q        <= 2'b11;
            blocked_q   <= 2'b11;
            last_q      <= 1'b1;
            gap_cnt_q   <= 4'd0;
            coll_cnt0_q <= '0;
            coll_cnt1_q <= '0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            blocked_q   <= blocked_d;
            last_q      <= last_d;
            gap_cnt_q   <= gap_cnt_d;
            coll_cnt0_q <= coll_cnt0_d;
            coll_cnt1_q <= coll_cnt1_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
        end
    end

    // Zero-latency pass-through between the owning master and the device.
    always_comb begin
        d_cs    = 1'b1;
        d_sclk  = 1'b0;
        d_mosi  = 1'b0;
        m0_miso = 1'b0;
        m1_miso = 1'b0;
        case (state_q)
            OWN0: begin
                d_cs    = m0_cs;
                d_sclk  = m0_sclk;
                d_mosi  = m0_mosi;
                m0_miso = d_miso;
            end
            OWN1: begin
                d_cs    = m1_cs;
                d_sclk  = m1_sclk;
                d_mosi  = m1_mosi;
                m1_miso = d_miso;
            end
            default: begin
                d_cs    = 1'b1;
            end
        endcase
    end

    assign grant     = grant_q;
    assign busy      = busy_q;
    assign coll_cnt0 = coll_cnt0_q;
    assign coll_cnt1 = coll_cnt1_q;

endmodule

// File: tb/tb_spi_device_arbiter.sv
// tb_spi_device_arbiter
// Drives directed board scenarios followed by random traffic. The expected
// device-side and status outputs for each cycle go into a scoreboard queue; a
// separate monitor pops one entry on each falling clock edge and compares it.
module tb_spi_device_arbiter;

    localparam int GAP   = 2;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0] grant;
        logic       busy;
        logic       dcs;
        logic       dsclk;
        logic       dmosi;
        logic       miso0;
        logic       miso1;
        int         cnt0;
        int         cnt1;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             m0_cs, m0_sclk, m0_mosi, m0_miso;
    logic             m1_cs, m1_sclk, m1_mosi, m1_miso;
    logic             d_cs, d_sclk, d_mosi, d_miso;
    logic [1:0]       grant;
    logic             busy;
    logic [CNT_W-1:0] coll_cnt0, coll_cnt1;
    logic             clr_stats;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the device, how much gap is left, who is masked.
    int owner;
    int gap_left;
    int last;
    int cnt[2];
    bit masked[2];
    bit prev_cs[2];

    logic [7:0] pattern = 8'hA5;

    always #5 clk = ~clk;

    spi_device_arbiter #(.GAP_CYCLES(GAP), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_cs     (m0_cs),
        .m0_sclk   (m0_sclk),
        .m0_mosi   (m0_mosi),
        .m0_miso   (m0_miso),
        .m1_cs     (m1_cs),
        .m1_sclk   (m1_sclk),
        .m1_mosi   (m1_mosi),
        .m1_miso   (m1_miso),
        .d_cs      (d_cs),
        .d_sclk    (d_sclk),
        .d_mosi    (d_mosi),
        .d_miso    (d_miso),
        .grant     (grant),
        .busy      (busy),
        .coll_cnt0 (coll_cnt0),
        .coll_cnt1 (coll_cnt1),
        .clr_stats (clr_stats)
    );

    task automatic model_reset();
        owner      = -1;
        gap_left   = 0;
        last       = 1;
        cnt[0]     = 0;
        cnt[1]     = 0;
        masked[0]  = 1'b1;
        masked[1]  = 1'b1;
        prev_cs[0] = 1'b1;
        prev_cs[1] = 1'b1;
    endtask

    // Outputs the arbitration rules demand for the current cycle.
    function automatic exp_t predict();
        exp_t e;
        e.grant = (owner == 0) ? 2'b01 : (owner == 1) ? 2'b10 : 2'b00;
        e.busy  = (owner >= 0) || (gap_left > 0);
        e.dcs   = 1'b1;
        e.dsclk = 1'b0;
        e.dmosi = 1'b0;
        e.miso0 = 1'b0;
        e.miso1 = 1'b0;
        if (owner == 0) begin
            e.dcs   = m0_cs;
            e.dsclk = m0_sclk;
            e.dmosi = m0_mosi;
            e.miso0 = d_miso;
        end else if (owner == 1) begin
            e.dcs   = m1_cs;
            e.dsclk = m1_sclk;
            e.dmosi = m1_mosi;
            e.miso1 = d_miso;
        end
        e.cnt0 = cnt[0];
        e.cnt1 = cnt[1];
        return e;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        bit cs[2];
        bit fell[2];
        bit coll[2];
        bit want[2];
        cs[0] = m0_cs;
        cs[1] = m1_cs;
        if (rst) begin
            model_reset();
        end else begin
            for (int j = 0; j < 2; j++) begin
                fell[j] = prev_cs[j] && !cs[j];
                coll[j] = 1'b0;
                want[j] = !cs[j] && !masked[j];
            end
            if (owner >= 0) begin
                coll[1 - owner] = fell[1 - owner];
                if (cs[owner]) begin
                    last     = owner;
                    owner    = -1;
                    gap_left = GAP;
                end
            end else if (gap_left > 0) begin
                coll[0]  = fell[0];
                coll[1]  = fell[1];
                gap_left = gap_left - 1;
            end else if (want[0] && want[1]) begin
                owner      = 1 - last;
                coll[last] = 1'b1;
            end else if (want[0]) begin
                owner = 0;
            end else if (want[1]) begin
                owner = 1;
            end
            for (int j = 0; j < 2; j++) begin
                if (cs[j]) masked[j] = 1'b0;
                else if (coll[j]) masked[j] = 1'b1;
                if (clr_stats) cnt[j] = 0;
                else if (coll[j] && cnt[j] < CMAX) cnt[j] = cnt[j] + 1;
                prev_cs[j] = cs[j];
            end
        end
    endtask

    // Holds the current inputs for n cycles, scoring each cycle and stepping the model.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            d_miso = 1'($urandom_range(0, 1));
            sb.push_back(predict());
            @(posedge clk);
            model_edge();
            #1;
        end
    endtask

    task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("grant",     16'(grant),     16'(e.grant));
        checkField("busy",      16'(busy),      16'(e.busy));
        checkField("d_cs",      16'(d_cs),      16'(e.dcs));
        checkField("d_sclk",    16'(d_sclk),    16'(e.dsclk));
        checkField("d_mosi",    16'(d_mosi),    16'(e.dmosi));
        checkField("m0_miso",   16'(m0_miso),   16'(e.miso0));
        checkField("m1_miso",   16'(m1_miso),   16'(e.miso1));
        checkField("coll_cnt0", 16'(coll_cnt0), 16'(e.cnt0));
        checkField("coll_cnt1", 16'(coll_cnt1), 16'(e.cnt1));
    endtask

    // Monitor: one scoreboard entry per cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput(e);
            end
        end
    end

    // Stimulus: directed board scenarios, then random traffic.
    initial begin
        rst       = 1'b1;
        m0_cs     = 1'b1;
        m0_sclk   = 1'b0;
        m0_mosi   = 1'b0;
        m1_cs     = 1'b1;
        m1_sclk   = 1'b0;
        m1_mosi   = 1'b0;
        d_miso    = 1'b0;
        clr_stats = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b0;

        $display("[TB] single master byte transfer");
        applyStimulus(1);
        m0_cs = 1'b0;
        applyStimulus(1);
        for (int i = 7; i >= 0; i--) begin
            m0_sclk = 1'b0;
            m0_mosi = pattern[i];
            applyStimulus(1);
            m0_sclk = 1'b1;
            applyStimulus(1);
        end
        m0_sclk = 1'b0;
        applyStimulus(1);
        m0_cs   = 1'b1;
        m0_mosi = 1'b0;
        applyStimulus(4);

        $display("[TB] simultaneous requests and round-robin");
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(1);
        m0_cs = 1'b0;
        m1_cs = 1'b0;
        applyStimulus(4);
        m0_cs = 1'b1;
        applyStimulus(6);
        m1_cs = 1'b1;
        applyStimulus(1);
        m0_cs = 1'b0;
        m1_cs = 1'b0;
        applyStimulus(4);
        m0_cs = 1'b1;
        m1_cs = 1'b1;
        applyStimulus(4);

        $display("[TB] mid-frame intrusion");
        m0_cs = 1'b0;
        applyStimulus(2);
        m1_cs = 1'b0;
        applyStimulus(50);
        m0_cs = 1'b1;
        applyStimulus(3);
        m1_cs = 1'b1;
        applyStimulus(4);

        $display("[TB] request during turnaround gap");
        m0_cs = 1'b0;
        applyStimulus(3);
        m0_cs = 1'b1;
        applyStimulus(1);
        m1_cs = 1'b0;
        applyStimulus(6);
        m1_cs = 1'b1;
        applyStimulus(4);

        $display("[TB] counter saturation and clear");
        m0_cs = 1'b0;
        applyStimulus(2);
        repeat (300) begin
            m1_cs = 1'b0;
            applyStimulus(1);
            m1_cs = 1'b1;
            applyStimulus(1);
        end
        m1_cs     = 1'b0;
        clr_stats = 1'b1;
        applyStimulus(1);
        clr_stats = 1'b0;
        applyStimulus(2);
        m0_cs = 1'b1;
        m1_cs = 1'b1;
        applyStimulus(4);

        $display("[TB] reset mid-transaction");
        m1_cs = 1'b0;
        applyStimulus(3);
        rst = 1'b1;
        applyStimulus(1);
        rst = 1'b0;
        applyStimulus(4);
        m1_cs = 1'b1;
        applyStimulus(1);
        m1_cs = 1'b0;
        applyStimulus(3);
        m1_cs = 1'b1;
        applyStimulus(4);

        $display("[TB] random traffic");
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) m0_cs = ~m0_cs;
            if ($urandom_range(0, 5) == 0) m1_cs = ~m1_cs;
            m0_sclk   = 1'($urandom_range(0, 1));
            m0_mosi   = 1'($urandom_range(0, 1));
            m1_sclk   = 1'($urandom_range(0, 1));
            m1_mosi   = 1'($urandom_range(0, 1));
            clr_stats = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            applyStimulus(1);
        end
        rst       = 1'b0;
        clr_stats = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
